// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: ALU mode codes, FSM states,
// the issued-operation bundle and the default operand settle time.
package alu_pkg;

    // Cycles operands are held on the ALU before its result is captured.
    localparam int SETTLE_CYCLES_DEFAULT = 2;

    // Mode codes understood by the shared ALU (passed through unchecked).
    typedef enum logic [2:0] {
        NOT_A = 3'd0,
        ADD   = 3'd1,
        AND   = 3'd2,
        OR    = 3'd3,
        XOR   = 3'd4,
        ROT   = 3'd5,
        ZERO  = 3'd6,
        ONE   = 3'd7
    } aluMode_e;

    // Arbiter FSM: wait for a request, hold operands on the ALU, present the response.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RESPOND = 2'd2
    } arbState_e;

    // One operation as driven onto the ALU.
    typedef struct packed {
        logic [2:0] sel;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
    } aluOp_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant, history advanced only when the
// caller signals that the current grant was taken.
module rr_arbiter2 (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       update,
    output logic [1:0] grant
);

    // High when req1 should win the next tie; cleared so req0 wins first.
    logic preferReq1;

    // Grant the lone requester, or the one not served last when both ask.
    always_comb begin
        // NOTE: defaulting every output first keeps all paths assigned, so no latch is inferred.
        grant = 2'b00;
        if (req0 && req1) begin
            grant = preferReq1 ? 2'b10 : 2'b01;
        end else if (req0) begin
            grant = 2'b01;
        end else if (req1) begin
            grant = 2'b10;
        end
    end

    // Move the tie-break preference away from whoever was just accepted.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values together.
        if (!reset) begin
            preferReq1 <= 1'b0;
        end else if (update && (grant != 2'b00)) begin
            preferReq1 <= grant[0];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: accepts one operation,
// holds its operands for SETTLE_CYCLES, captures the result and presents it
// with valid/ready before accepting the next operation.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic       req1_valid,
    output logic       req0_ready,
    output logic       req1_ready,
    input  logic [2:0] req0_sel,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [3:0] req0_c,
    input  logic [2:0] req1_sel,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic [3:0] req1_c,
    output logic [2:0] alu_sel,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_c,
    input  logic [3:0] alu_result,
    input  logic       alu_carry,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_result,
    output logic       rsp_carry
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    arbState_e  state;
    arbState_e  stateNext;
    logic [3:0] settleCount;
    logic [1:0] grant;
    logic       idle;
    logic       accept;
    logic       captureNow;
    aluOp_t     req0Op;
    aluOp_t     req1Op;
    aluOp_t     issued;

    assign idle   = (state == IDLE);
    assign req0Op = {req0_sel, req0_a, req0_b, req0_c};
    assign req1Op = {req1_sel, req1_a, req1_b, req1_c};

    // Requests are only visible to the arbiter while idle, so a withdrawn
    // request outside IDLE can never win or move the history.
    rr_arbiter2 u_rr (
        .clock  (clock),
        .reset  (reset),
        .req0   (req0_valid && idle),
        .req1   (req1_valid && idle),
        .update (accept),
        .grant  (grant)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        stateNext  = state;
        accept     = 1'b0;
        captureNow = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (grant != 2'b00) begin
                    accept     = 1'b1;
                    req0_ready = grant[0];
                    req1_ready = grant[1];
                    stateNext  = ISSUE;
                end
            end
            ISSUE: begin
                if (settleCount == 4'd1) begin
                    captureNow = 1'b1;
                    stateNext  = RESPOND;
                end
            end
            RESPOND: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Settle countdown: loaded on acceptance, one tick per ISSUE cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            settleCount <= '0;
        end else if (accept) begin
            settleCount <= SETTLE_LOAD;
        end else if (state == ISSUE) begin
            settleCount <= settleCount - 4'd1;
        end
    end

    // Operand registers load on acceptance; response registers load when the ALU has settled.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: these datapath registers are reset because their values are visible on the ports.
        if (!reset) begin
            issued     <= '0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
        end else begin
            if (accept) begin
                issued <= grant[1] ? req1Op : req0Op;
                rsp_id <= grant[1];
            end
            if (captureNow) begin
                rsp_result <= alu_result;
                rsp_carry  <= alu_carry;
            end
        end
    end

    assign alu_sel = issued.sel;
    assign alu_a   = issued.a;
    assign alu_b   = issued.b;
    assign alu_c   = issued.c;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2: cycles operands are held on the ALU before the result is captured (legal range 1..15).
REQ-002 SHALL have port clock, input, 1: sole clock, rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port req0_valid / req1_valid, input, 1 each: requester n has an operation pending.
REQ-005 SHALL have port req0_ready / req1_ready, output, 1 each: requester n accepted this cycle.
REQ-006 SHALL have port req0_sel / req1_sel, input, 3 each: ALU mode code.
REQ-007 SHALL have port req0_a, req0_b, req0_c / req1_a, req1_b, req1_c, input, 4 each: operands.
REQ-008 SHALL have port alu_sel, output, 3: mode driven to the shared ALU.
REQ-009 SHALL have port alu_a, alu_b, alu_c, output, 4 each: operands driven to the ALU.
REQ-010 SHALL have port alu_result, input, 4: ALU result (RegOut).
REQ-011 SHALL have port alu_carry, input, 1: ALU carry (Carryout).
REQ-012 SHALL have port rsp_valid, output, 1: a response is presented.
REQ-013 SHALL have port rsp_ready, input, 1: the consumer takes the response.
REQ-014 SHALL have port rsp_id, output, 1: the requester that owns the response.
REQ-015 SHALL have port rsp_result, output, 4: captured alu_result.
REQ-016 SHALL have port rsp_carry, output, 1: captured alu_carry.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE and RESPOND.
REQ-018 In IDLE with at least one reqN_valid high, the block SHALL assert exactly one reqN_ready combinationally in the same cycle; that cycle is the acceptance cycle N.
REQ-019 Arbitration SHALL be round-robin: when both requesters are valid, grant goes to the one not granted last; the first grant after reset goes to req0.
REQ-020 When only one requester is valid, it SHALL be granted regardless of round-robin history.
REQ-021 The round-robin history SHALL update only on acceptance.
REQ-022 reqN_ready SHALL be low in ISSUE and RESPOND.
REQ-023 A requester dropping valid before acceptance SHALL be legal and SHALL cause no side effect.
REQ-024 On acceptance, sel/a/b/c and the grant id SHALL be registered onto alu_sel/alu_a/alu_b/alu_c and rsp_id, and the FSM SHALL go to ISSUE.
REQ-025 ISSUE SHALL last exactly SETTLE_CYCLES cycles, N+1..N+SETTLE_CYCLES, counted down by a 4-bit counter.
REQ-026 On the clock edge that ends cycle N+SETTLE_CYCLES, alu_result/alu_carry SHALL be captured into rsp_result/rsp_carry and the FSM SHALL go to RESPOND.
REQ-027 rsp_valid SHALL be high only in RESPOND, first in cycle N+SETTLE_CYCLES+1.
REQ-028 While rsp_valid is high and rsp_ready is low, rsp_id/rsp_result/rsp_carry SHALL remain stable.
REQ-029 rsp_valid && rsp_ready SHALL return the FSM to IDLE on the next edge; the next acceptance can occur no earlier than that IDLE cycle, so minimum spacing between acceptances is SETTLE_CYCLES+2 cycles.
REQ-030 alu_sel and alu_a/alu_b/alu_c SHALL hold their last issued values through RESPOND and IDLE, changing only on acceptance.
REQ-031 All eight alu_sel codes SHALL be passed through unchecked; carry is captured for every mode.

Reset
REQ-032 When reset is low, the FSM SHALL go to IDLE immediately, asynchronously, and the counter SHALL clear.
REQ-033 When reset is low, rsp_valid, rsp_id, rsp_result and rsp_carry SHALL be 0.
REQ-034 When reset is low, alu_sel, alu_a, alu_b and alu_c SHALL be 0, and the round-robin history SHALL point to req0.
REQ-035 Reset asserted in ISSUE or RESPOND SHALL abort the operation with no response issued.
REQ-036 The first acceptance SHALL be possible in the first cycle after reset deasserts.

Structure
REQ-037 Package alu_pkg SHALL hold the ALU mode constants NOT_A=0, ADD=1, AND=2, OR=3, XOR=4, ROT=5, ZERO=6, ONE=7, the FSM state encoding and the default of SETTLE_CYCLES.
REQ-038 The two-way round-robin grant logic SHALL be a sub-module rr_arbiter2 (inputs: two requests and an update strobe; outputs: one-hot grant).

Verification
REQ-039 Single request: req0 sel=2 (AND), a=4'hC, b=4'hA with SETTLE_CYCLES=2 and rsp_ready=1 -> req0_ready in cycle N, alu_sel=2 from N+1, rsp_valid in N+3 with rsp_id=0, rsp_result=4'h8.
REQ-040 Contention: both requesters valid continuously, req0 sel=1 (ADD) a=4'h9 b=4'h5 c=4'h3, req1 sel=0 (NOT_A) a=4'h3 -> grants alternate req0, req1, req0; responses are (id 0, result 4'h1, carry 1), (id 1, result 4'hC, carry 0).
REQ-041 Backpressure: rsp_ready held low 5 cycles after rsp_valid rises -> rsp_valid, rsp_result and rsp_id stay stable, both reqN_ready stay 0, and IDLE is entered on the cycle after rsp_ready rises.
REQ-042 Reset mid-ISSUE: pull reset low in cycle N+1 -> all outputs go to 0 without waiting for a clock edge, no rsp_valid appears, and the next grant after release goes to req0.
REQ-043 Withdrawn request: req1_valid pulsed in one cycle while FSM is in ISSUE, then dropped -> req1 is never granted and no extra response is produced.
